// File: rtl/nios_mult_unit.sv
// Two-stage pipelined DATA_W x DATA_W multiplier built from CELL_W partial-product cells.
// Define NIOS_MULT_UNIT_HI_EN to build the high-word ops (MULXSS/MULXSU/MULXUU); default is low word only.
module nios_mult_unit #(
   parameter int DATA_W = 32,
   parameter int CELL_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result
);

   localparam int N = DATA_W / CELL_W;
`ifdef NIOS_MULT_UNIT_HI_EN
   localparam int SUM_W = 2 * DATA_W;
`else
   localparam int SUM_W = DATA_W;
`endif

   logic [2*CELL_W-1:0] r_cell [N][N];
   logic                r_v1;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_result;
   logic                w_adv;
   logic [SUM_W-1:0]    w_sum;
   logic [DATA_W-1:0]   w_result;

   // Global stall: both stages advance together or hold together.
   assign w_adv      = ~r_out_valid | out_ready;
   assign in_ready   = w_adv;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;

   always_ff @(posedge clk) begin
      if (w_adv) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
`ifdef NIOS_MULT_UNIT_HI_EN
               r_cell[i][j] <= {{CELL_W{1'b0}}, in_a[i*CELL_W +: CELL_W]} *
                               {{CELL_W{1'b0}}, in_b[j*CELL_W +: CELL_W]};
`else
               // Cells weighted at or above 2^DATA_W never reach the low word.
               if (i + j < N)
                  r_cell[i][j] <= {{CELL_W{1'b0}}, in_a[i*CELL_W +: CELL_W]} *
                                  {{CELL_W{1'b0}}, in_b[j*CELL_W +: CELL_W]};
               else
                  r_cell[i][j] <= '0;
`endif
            end
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            w_sum = w_sum + (SUM_W'(r_cell[i][j]) << (CELL_W * (i + j)));
   end

`ifdef NIOS_MULT_UNIT_HI_EN
   logic [1:0]        r_op;
   logic [DATA_W-1:0] r_corr_a;
   logic [DATA_W-1:0] r_corr_b;
   logic [DATA_W-1:0] w_hi;

   // Signed high words: subtract the operand weighted by the other operand's sign bit.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_op     <= in_op;
         r_corr_a <= (in_op == 2'd1 && in_b[DATA_W-1]) ? in_a : '0;
         r_corr_b <= ((in_op == 2'd1 || in_op == 2'd2) && in_a[DATA_W-1]) ? in_b : '0;
      end
   end

   assign w_hi     = w_sum[SUM_W-1:DATA_W] - r_corr_a - r_corr_b;
   assign w_result = (r_op == 2'd0) ? w_sum[DATA_W-1:0] : w_hi;
`else
   logic w_unused_op;
   assign w_unused_op = ^in_op;
   assign w_result    = w_sum;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1         <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
      end else begin
         if (flush) begin
            r_v1        <= 1'b0;
            r_out_valid <= 1'b0;
         end else if (w_adv) begin
            r_v1        <= in_valid;
            r_out_valid <= r_v1;
         end
         if (w_adv)
            r_out_result <= w_result;
      end
   end

endmodule

// File: tb/tb_nios_mult_unit.sv
// Directed bench for nios_mult_unit: a 32-bit instance for the main sequence, a 64-bit one for the wide case.
// Expected values follow NIOS_MULT_UNIT_HI_EN when it is defined for the whole build.
module tb_nios_mult_unit;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_result;
   logic [1:0]  in_op;
   logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
   logic [63:0] in_a_w, in_b_w, out_result_w;
   logic [1:0]  in_op_w;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_ff [4];
   logic [31:0] exp_80 [3];
   logic [63:0] exp_wide;

   nios_mult_unit #(.DATA_W(32), .CELL_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
   );

   nios_mult_unit #(.DATA_W(64), .CELL_W(16)) dut_w (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid_w), .in_ready(in_ready_w),
      .in_a(in_a_w), .in_b(in_b_w), .in_op(in_op_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w), .out_result(out_result_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef NIOS_MULT_UNIT_HI_EN
      exp_ff   = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      exp_80   = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
      exp_wide = 64'h0;
`else
      exp_ff   = '{32'h1, 32'h1, 32'h1, 32'h1};
      exp_80   = '{32'h0, 32'h0, 32'h0};
      exp_wide = 64'h5_0000_000F;
`endif
      reset = 1'b1; flush = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
      in_valid_w = 1'b0; in_a_w = '0; in_b_w = '0; in_op_w = '0; out_ready_w = 1'b1;

      tick(); tick();
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_result", 64'(out_result), 64'h0);
      check("rst_in_ready", 64'(in_ready), 64'h1);
      check("rst_wide_valid", 64'(out_valid_w), 64'h0);
      reset = 1'b0; out_ready = 1'b1;
      tick();

      // All-ones operands, ops 0..3 back to back; each result is out two cycles after being presented.
      for (int t = 0; t < 5; t++) begin
         in_valid = (t < 4); in_op = 2'(t); in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
         tick();
         if (t >= 1) begin
            check("ff_valid", 64'(out_valid), 64'h1);
            check("ff_result", 64'(out_result), 64'(exp_ff[t-1]));
         end
      end
      in_valid = 1'b0;
      tick();
      check("ff_drained", 64'(out_valid), 64'h0);

      for (int t = 0; t < 4; t++) begin
         in_valid = (t < 3); in_op = 2'(t + 1); in_a = 32'h8000_0000; in_b = 32'h8000_0000;
         tick();
         if (t >= 1) check("msb_result", 64'(out_result), 64'(exp_80[t-1]));
      end
      in_valid = 1'b0;
      tick();

      // Back-pressure: two ops fill the pipe, the third waits at the input.
      out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd0; in_a = 32'd3; in_b = 32'd5;
      #1;
      check("bp_ready_empty", 64'(in_ready), 64'h1);
      tick();
      in_a = 32'h1234_5678; in_b = 32'h10;
      tick();
      in_a = 32'h0001_2345; in_b = 32'h0001_0000;
      for (int k = 0; k < 5; k++) begin
         check("bp_in_ready", 64'(in_ready), 64'h0);
         check("bp_hold_valid", 64'(out_valid), 64'h1);
         check("bp_hold_result", 64'(out_result), 64'd15);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("bp_drain1_valid", 64'(out_valid), 64'h1);
      check("bp_drain1", 64'(out_result), 64'h2345_6780);
      tick();
      check("bp_drain2_valid", 64'(out_valid), 64'h1);
      check("bp_drain2", 64'(out_result), 64'h2345_0000);
      tick();
      check("bp_drain_end", 64'(out_valid), 64'h0);

      // Flush kills the op in stage 1 and the op presented with the flush.
      in_valid = 1'b1; in_a = 32'd7; in_b = 32'd9;
      tick();
      in_a = 32'd11; in_b = 32'd13;
      tick();
      check("fl_pre_result", 64'(out_result), 64'd63);
      flush = 1'b1; in_a = 32'd17; in_b = 32'd19;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("fl_killed", 64'(out_valid), 64'h0);
         tick();
      end
      in_valid = 1'b1; in_a = 32'h0001_0001; in_b = 32'h0001_0001;
      tick();
      in_valid = 1'b0;
      check("fl_next_lat1", 64'(out_valid), 64'h0);
      tick();
      check("fl_next_valid", 64'(out_valid), 64'h1);
      check("fl_next_result", 64'(out_result), 64'h0002_0001);
      tick();
      check("fl_next_done", 64'(out_valid), 64'h0);

      // Reset with a valid result at the output and a transfer pending.
      in_valid = 1'b1; in_a = 32'd2; in_b = 32'd3;
      tick();
      in_a = 32'd4; in_b = 32'd5;
      tick();
      check("mr_pre_result", 64'(out_result), 64'd6);
      reset = 1'b1;
      tick();
      check("mr_out_valid", 64'(out_valid), 64'h0);
      check("mr_out_result", 64'(out_result), 64'h0);
      check("mr_in_ready", 64'(in_ready), 64'h1);
      reset = 1'b0; in_valid = 1'b0;
      tick();
      check("mr_after", 64'(out_valid), 64'h0);

      in_valid_w = 1'b1; in_a_w = 64'h1_0000_0003; in_b_w = 64'd5; in_op_w = 2'd3;
      tick();
      in_valid_w = 1'b0;
      tick();
      check("wide_valid", 64'(out_valid_w), 64'h1);
      check("wide_result", out_result_w, exp_wide);
      tick();
      check("wide_done", 64'(out_valid_w), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
